counter_readback: RTL
=====================

Name: counter_readback

Overview:
- Read-side path of one 8254 counter: returns count and status bytes to the CPU data bus.
- Implements the counter-latch command, the read-back command (count and/or status), and the LSB/MSB read flip-flop selected by the programmed RW field.
- Sits between the counter core (live count, OUT, null-count) and the bus interface's read strobe.
- Complements the write path, which loads control words and counts into the counter.

Parameters:
- COUNT_W, 16, counter width; must equal 2*DATA_W.
- DATA_W, 8, bus byte width.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- rw_mode  in  2  programmed RW field (01 LSB only, 10 MSB only, 11 LSB then MSB)
- mode  in  3  programmed counter mode, reported in status
- ctrl_wr  in  1  one-cycle pulse: new control word written to this counter
- latch_cmd  in  1  one-cycle pulse: counter-latch command for this counter
- rb_cmd  in  1  one-cycle pulse: read-back command addressing this counter
- rb_count_n  in  1  read-back: 0 = latch count
- rb_status_n  in  1  read-back: 0 = latch status
- live_count  in  COUNT_W  current counting-element value from the core
- out_pin  in  1  current OUT level
- null_count  in  1  1 = written count not yet loaded into the counting element
- rd_en  in  1  one-cycle CPU read strobe
- data_out  out  DATA_W  read data, registered
- data_valid  out  1  one-cycle pulse, data_out valid
- count_latched  out  1  count latch holds a value
- status_latched  out  1  status latch holds a value

Behaviour:
- Reset (rst_n=0 at clk edge) clears:
  - data_out=0, data_valid=0, count_latched=0, status_latched=0
  - read flip-flop (rd_ff) = LSB
  - count latch = 0, status latch = 0
- Latency: data_out and data_valid are asserted on the cycle after rd_en. Every rd_en produces exactly one data_valid.
- Status byte: {out_pin, null_count, rw_mode[1:0], mode[2:0], 1'b0} (BCD bit always 0), sampled on the command cycle.
- Count latch:
  - latch_cmd, or rb_cmd with rb_count_n=0, captures live_count if count_latched=0.
  - The command is ignored while count_latched=1; the first latched value is kept.
- Status latch:
  - rb_cmd with rb_status_n=0 captures the status byte if status_latched=0.
  - The command is ignored while status_latched=1.
- Read source priority: status latch, then count latch, then live_count (unlatched read).
- Status read: returns the status byte and clears status_latched. rd_ff is unchanged.
- Count read, rw_mode=01: returns the LSB.
  - If the count was latched, clears count_latched.
- Count read, rw_mode=10: returns the MSB.
  - If the count was latched, clears count_latched.
- Count read, rw_mode=11:
  - rd_ff=LSB: returns the LSB and sets rd_ff=MSB.
  - rd_ff=MSB: returns the MSB, sets rd_ff=LSB, and clears count_latched if set.
  - The latched value holds across both bytes.
- Count read, rw_mode=00 (illegal): returns the LSB, with no state change beyond the read itself.
- ctrl_wr: clears both latches and sets rd_ff=LSB. It overrides any latch_cmd, rb_cmd, or read-state update in the same cycle.
- rd_en and a latch command in the same cycle:
  - The read is served from pre-cycle state.
  - The capture then applies to the post-read state. Example: a read that empties the count latch plus latch_cmd recaptures live_count.
- Unlatched rw_mode=11 reads may tear (LSB and MSB taken from different live values). This is permitted.
- rd_en with no pending work is always legal.

Optional Feature:
- Macro: I8254_READ_BACK_EN
- Defined: rb_cmd, rb_count_n and rb_status_n are honoured as above.
- Undefined:
  - rb_* inputs are ignored.
  - status_latched is constant 0.
  - The status latch register is not built.
  - latch_cmd is the only way to latch the count.

Decomposition:
- Package i8254_pkg:
  - RW_LATCH=2'b00, RW_LSB=2'b01, RW_MSB=2'b10, RW_LSB_MSB=2'b11
  - status-byte bit positions (OUT=7, NULL=6, RW=5:4, MODE=3:1, BCD=0)
  - rd_ff encoding
- No sub-module; single flat block. This is shared package use only.

Test Plan:
- Reset, then rw_mode=11, live_count=16'h1234, two rd_en -> data_out 8'h34 then 8'h12; data_valid high one cycle after each strobe.
- rw_mode=11, latch_cmd at live_count=16'hABCD; live changes to 16'h0001; second latch_cmd at 16'h0002; two reads -> 8'hCD, 8'hAB; count_latched falls after the second read; third read -> live LSB.
- rb_cmd with rb_count_n=0, rb_status_n=0; out_pin=1, null_count=0, rw_mode=01, mode=3'b010, live_count=16'h0050; two reads -> 8'h94 then 8'h50 (requires I8254_READ_BACK_EN).
- rw_mode=11, latch 16'h5A5A, read one byte (8'h5A), then ctrl_wr -> count_latched=0, rd_ff=LSB; next read returns live LSB.
- rw_mode=01, count latched at 16'h00FF, rd_en and latch_cmd in the same cycle with live_count=16'h0077 -> data_out 8'hFF; count_latched stays 1; next read -> 8'h77.
- Build without I8254_READ_BACK_EN, pulse rb_cmd with both enables low -> no latch flags set; read returns live LSB.

Source files
------------

// File: rtl/counter_readback_pkg.sv
// Shared 8254 encodings: RW field, status-byte bit positions, read flip-flop.
// Combinational helpers only; no handshake.
package i8254_pkg;

  typedef enum logic [1:0] {
    RW_LATCH   = 2'b00,
    RW_LSB     = 2'b01,
    RW_MSB     = 2'b10,
    RW_LSB_MSB = 2'b11
  } rw_e;

  typedef enum logic {
    RDFF_LSB = 1'b0,
    RDFF_MSB = 1'b1
  } rdff_e;

  localparam int ST_OUT     = 7;
  localparam int ST_NULL    = 6;
  localparam int ST_RW_HI   = 5;
  localparam int ST_RW_LO   = 4;
  localparam int ST_MODE_HI = 3;
  localparam int ST_MODE_LO = 1;
  localparam int ST_BCD     = 0;

  function automatic logic [7:0] status_byte(input logic       out_lvl,
                                             input logic       nul,
                                             input logic [1:0] rw,
                                             input logic [2:0] md);
    logic [7:0] s;
    s                        = '0;
    s[ST_OUT]                = out_lvl;
    s[ST_NULL]               = nul;
    s[ST_RW_HI:ST_RW_LO]     = rw;
    s[ST_MODE_HI:ST_MODE_LO] = md;
    s[ST_BCD]                = 1'b0;
    return s;
  endfunction

endpackage

// File: rtl/counter_readback_if.sv
// Read-side bundle between CPU/core (master) and the readback block (slave).
// No latency of its own; strobes are single-cycle pulses, no backpressure.
interface counter_readback_if #(
  parameter int COUNT_W = 16,
  parameter int DATA_W  = 8
);
  logic [1:0]         rw_mode;
  logic [2:0]         mode;
  logic               ctrl_wr;
  logic               latch_cmd;
  logic               rb_cmd;
  logic               rb_count_n;
  logic               rb_status_n;
  logic [COUNT_W-1:0] live_count;
  logic               out_pin;
  logic               null_count;
  logic               rd_en;
  logic [DATA_W-1:0]  data_out;
  logic               data_valid;
  logic               count_latched;
  logic               status_latched;

  modport master (
    output rw_mode, mode, ctrl_wr, latch_cmd, rb_cmd, rb_count_n, rb_status_n,
    output live_count, out_pin, null_count, rd_en,
    input  data_out, data_valid, count_latched, status_latched
  );

  modport slave (
    input  rw_mode, mode, ctrl_wr, latch_cmd, rb_cmd, rb_count_n, rb_status_n,
    input  live_count, out_pin, null_count, rd_en,
    output data_out, data_valid, count_latched, status_latched
  );
endinterface

// File: rtl/counter_readback.sv
// 8254 counter read path: count/status latches and LSB/MSB read flip-flop (read-back via I8254_READ_BACK_EN).
// Latency: data_out/data_valid registered, one cycle after rd_en.
// Backpressure: none; every rd_en yields exactly one data_valid pulse.
module counter_readback
  import i8254_pkg::*;
#(
  parameter int COUNT_W = 16,
  parameter int DATA_W  = 8
) (
  input logic               clk,
  input logic               rst_n,
  counter_readback_if.slave bus
);

  logic [DATA_W-1:0]  data_q, data_d;
  logic               vld_q, vld_d;
  logic               cnt_lat_q, cnt_lat_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  rdff_e              rdff_q, rdff_d;
  logic [COUNT_W-1:0] src;
  logic               cnt_cmd;

`ifdef I8254_READ_BACK_EN
  logic        st_lat_q, st_lat_d;
  logic [7:0]  st_q, st_d;
  logic        st_cmd;

  assign cnt_cmd = bus.latch_cmd | (bus.rb_cmd & ~bus.rb_count_n);
  assign st_cmd  = bus.rb_cmd & ~bus.rb_status_n;
`else
  logic unused_rb;

  assign cnt_cmd   = bus.latch_cmd;
  assign unused_rb = ^{bus.rb_cmd, bus.rb_count_n, bus.rb_status_n,
                       bus.out_pin, bus.null_count, bus.mode};
`endif

  assign src = cnt_lat_q ? cnt_q : bus.live_count;

  always_comb begin
    data_d    = data_q;
    vld_d     = 1'b0;
    cnt_lat_d = cnt_lat_q;
    cnt_d     = cnt_q;
    rdff_d    = rdff_q;
`ifdef I8254_READ_BACK_EN
    st_lat_d  = st_lat_q;
    st_d      = st_q;
`endif

    if (bus.rd_en) begin
      vld_d = 1'b1;
`ifdef I8254_READ_BACK_EN
      if (st_lat_q) begin
        data_d   = st_q;
        st_lat_d = 1'b0;
      end else
`endif
      begin
        case (rw_e'(bus.rw_mode))
          RW_LSB: begin
            data_d    = src[DATA_W-1:0];
            cnt_lat_d = 1'b0;
          end
          RW_MSB: begin
            data_d    = src[COUNT_W-1:DATA_W];
            cnt_lat_d = 1'b0;
          end
          RW_LSB_MSB: begin
            if (rdff_q == RDFF_LSB) begin
              data_d = src[DATA_W-1:0];
              rdff_d = RDFF_MSB;
            end else begin
              data_d    = src[COUNT_W-1:DATA_W];
              rdff_d    = RDFF_LSB;
              cnt_lat_d = 1'b0;
            end
          end
          default: data_d = src[DATA_W-1:0];
        endcase
      end
    end

    // Captures look at post-read flags so a read that empties a latch can be refilled in the same cycle.
    if (cnt_cmd && !cnt_lat_d) begin
      cnt_d     = bus.live_count;
      cnt_lat_d = 1'b1;
    end
`ifdef I8254_READ_BACK_EN
    if (st_cmd && !st_lat_d) begin
      st_d     = status_byte(bus.out_pin, bus.null_count, bus.rw_mode, bus.mode);
      st_lat_d = 1'b1;
    end
`endif

    if (bus.ctrl_wr) begin
      cnt_lat_d = 1'b0;
      rdff_d    = RDFF_LSB;
`ifdef I8254_READ_BACK_EN
      st_lat_d  = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q    <= '0;
      vld_q     <= 1'b0;
      cnt_lat_q <= 1'b0;
      cnt_q     <= '0;
      rdff_q    <= RDFF_LSB;
    end else begin
      data_q    <= data_d;
      vld_q     <= vld_d;
      cnt_lat_q <= cnt_lat_d;
      cnt_q     <= cnt_d;
      rdff_q    <= rdff_d;
    end
  end

`ifdef I8254_READ_BACK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_lat_q <= 1'b0;
      st_q     <= '0;
    end else begin
      st_lat_q <= st_lat_d;
      st_q     <= st_d;
    end
  end

  assign bus.status_latched = st_lat_q;
`else
  assign bus.status_latched = 1'b0;
`endif

  assign bus.data_out      = data_q;
  assign bus.data_valid    = vld_q;
  assign bus.count_latched = cnt_lat_q;

endmodule
